// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and FSM state encoding for the nibble-serial adder
package cla_pkg;
  localparam int NIBBLES_DEF = 4;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/cla_4bit.sv
// CLA_4bit: 4-bit carry-lookahead adder
//   A, B : 4-bit operands, Cin : carry in
//   Sum  : 4-bit sum,      Cout: carry out
module CLA_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);
  logic [3:0] p, g;
  logic [4:0] c;
  assign p = A ^ B;
  assign g = A & B;
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & Cin);
  assign Sum = p ^ c[3:0];
  assign Cout = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: W-bit adder processing one nibble per clock through a shared 4-bit CLA
//   clk, rst_n (async, active-low) | start, a, b, cin: request and operands (latched on accept)
//   busy: high while adding | done: one-cycle result-valid pulse | sum, cout, overflow: held result
module nibble_serial_adder
  import cla_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                      cout,
  output logic                      overflow
);
  localparam int W = NIBBLE_W * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  state_t state;
  logic [W-1:0] a_q, b_q;
  logic carry;
  logic [IW-1:0] idx;
  logic [3:0] a_nib, b_nib, cla_sum;
  logic cla_cout;
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_q[NIBBLE_W*i +: NIBBLE_W];
        b_nib = b_q[NIBBLE_W*i +: NIBBLE_W];
      end
    end
  end
  // Carry between nibbles travels only through the carry register.
  CLA_4bit u_cla (
    .A   (a_nib),
    .B   (b_nib),
    .Cin (carry),
    .Sum (cla_sum),
    .Cout(cla_cout)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      overflow <= 1'b0;
      idx <= '0;
      carry <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      case (state)
        ADD: begin
          for (int i = 0; i < NIBBLES; i++)
            if (idx == IW'(i)) sum[NIBBLE_W*i +: NIBBLE_W] <= cla_sum;
          carry <= cla_cout;
          if (idx == IW'(NIBBLES - 1)) begin
            cout <= cla_cout;
            overflow <= (a_q[W-1] == b_q[W-1]) && (cla_sum[3] != a_q[W-1]);
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            a_q <= a;
            b_q <= b;
            carry <= cin;
            idx <= '0;
            sum <= '0;
            cout <= 1'b0;
            overflow <= 1'b0;
            state <= ADD;
            busy <= 1'b1;
          end else begin
            state <= IDLE;
            busy <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic cin = 1'b0;
  logic busy, done, cout, overflow;
  logic [15:0] sum;
  int tests_run = 0;
  int failed = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    tests_run++;
    if ({busy, done, cout, overflow} !== 4'b0) begin
      failed++;
      $display("FAIL reset_flags got %b want 0000", {busy, done, cout, overflow});
    end
    tests_run++;
    if (sum !== 16'h0) begin
      failed++;
      $display("FAIL reset_sum got %h want 0000", sum);
    end
    rst_n = 1'b1;
    step();
    step();
    tests_run++;
    if ({busy, done} !== 2'b00) begin
      failed++;
      $display("FAIL idle_after_reset busy/done got %b want 00", {busy, done});
    end
  endtask

  task automatic test_add(input string nm, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic [15:0] es, input logic ec, input logic eo);
    int n;
    a = av; b = bv; cin = ci; start = 1'b1;
    step();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      failed++;
      $display("FAIL %s busy_after_accept got %b want 1", nm, busy);
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    tests_run++;
    if (n !== 4) begin
      failed++;
      $display("FAIL %s latency got %0d want 4", nm, n);
    end
    tests_run++;
    if ({sum, cout, overflow, busy} !== {es, ec, eo, 1'b0}) begin
      failed++;
      $display("FAIL %s result sum=%h cout=%b ovf=%b busy=%b want sum=%h cout=%b ovf=%b busy=0",
               nm, sum, cout, overflow, busy, es, ec, eo);
    end
    step();
    tests_run++;
    if ({done, sum, cout, overflow} !== {1'b0, es, ec, eo}) begin
      failed++;
      $display("FAIL %s hold done=%b sum=%h cout=%b ovf=%b want done=0 sum=%h", nm, done, sum, cout, overflow, es);
    end
  endtask

  task automatic test_vectors();
    test_add("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    test_add("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    test_add("overflow", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    test_add("neg_ovf", 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
  endtask

  task automatic test_start_ignored();
    int n, extra;
    a = 16'h0003; b = 16'h0004; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    step();
    start = 1'b0;
    n = 2;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    tests_run++;
    if (n !== 4) begin
      failed++;
      $display("FAIL ignore_latency got %0d want 4", n);
    end
    tests_run++;
    if ({sum, cout, overflow} !== {16'h0007, 1'b0, 1'b0}) begin
      failed++;
      $display("FAIL ignore_result sum=%h cout=%b ovf=%b want 0007 0 0", sum, cout, overflow);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    tests_run++;
    if (extra !== 0 || sum !== 16'h0007) begin
      failed++;
      $display("FAIL ignore_no_extra activity=%0d sum=%h want 0 0007", extra, sum);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    tests_run++;
    if (sum !== 16'h5555) begin
      failed++;
      $display("FAIL b2b_first sum=%h want 5555", sum);
    end
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    tests_run++;
    if ({done, busy} !== 2'b01) begin
      failed++;
      $display("FAIL b2b_accept done/busy got %b want 01", {done, busy});
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    tests_run++;
    if (n !== 4 || {sum, cout, overflow} !== {16'h0000, 1'b1, 1'b0}) begin
      failed++;
      $display("FAIL b2b_second lat=%0d sum=%h cout=%b ovf=%b want 4 0000 1 0", n, sum, cout, overflow);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int act;
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    tests_run++;
    if (sum !== 16'h0055 || busy !== 1'b1) begin
      failed++;
      $display("FAIL mid_partial sum=%h busy=%b want 0055 1", sum, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, cout, overflow, sum} !== 20'h0) begin
      failed++;
      $display("FAIL mid_async_reset busy=%b done=%b cout=%b ovf=%b sum=%h want all 0",
               busy, done, cout, overflow, sum);
    end
    #2 rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) act++;
    end
    tests_run++;
    if (act !== 0 || sum !== 16'h0) begin
      failed++;
      $display("FAIL mid_stays_idle activity=%0d sum=%h want 0 0000", act, sum);
    end
    test_add("after_reset", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
